// File: rtl/ofs_fim_pcie_pkg.sv
// Shared types and constants for the PCIe control-shadow source.
// Bit positions of the 7-bit per-function config word are listed here so
// producers and consumers agree on the layout.
package ofs_fim_pcie_pkg;

  localparam int CTL_SHDW_CFG_W = 7;

  localparam int SHDW_ATS_EN    = 6;
  localparam int SHDW_TPH_EN    = 5;
  localparam int SHDW_TPH_ST_HI = 4;
  localparam int SHDW_TPH_ST_LO = 3;
  localparam int SHDW_MSIX_EN   = 2;
  localparam int SHDW_MSIX_MASK = 1;
  localparam int SHDW_BME       = 0;

  typedef struct packed {
    logic [1:0]                pf_num;
    logic [10:0]               vf_num;
    logic                      vf_active;
    logic [CTL_SHDW_CFG_W-1:0] cfg;
  } t_ctl_shdw;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    EMIT,
    GAP
  } t_shdw_tx_state;

endpackage

// File: rtl/pcie_ctl_shdw_tx_pick.sv
// Fixed-priority picker: reports whether any bit of the dirty vector is set
// and the index of the lowest set bit (0 when none are set).
module pcie_ctl_shdw_pick #(
  parameter int N  = 20,
  parameter int IW = 5
) (
  input  logic [N-1:0]  vec,
  output logic          any_set,
  output logic [IW-1:0] low_idx
);

  // Scan from the top down so the lowest set index is the one left standing.
  always_comb begin
    any_set = |vec;
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) low_idx = IW'(i);
    end
  end

endmodule

// File: rtl/pcie_ctl_shdw_tx.sv
// Control-shadow source: keeps a shadow of the per-function config bits for
// all PFs and VFs and streams single-entry updates to the shadow consumer,
// either for entries that were written or as a full-table sweep on request.
// Optional build macro CTL_SHDW_STATS_EN adds the upd_cnt/sweep_cnt counters.
//
//   state | meaning
//   IDLE  | waiting; a pending sweep wins over dirty entries
//   SWEEP | emitting table entry idx, walking 0..N-1
//   EMIT  | emitting the single dirty entry idx
//   GAP   | enforcing UPD_GAP idle cycles after a pulse, then SWEEP or IDLE
module pcie_ctl_shdw_tx
  import ofs_fim_pcie_pkg::*;
#(
  parameter int NUM_PF       = 4,
  parameter int NUM_VF       = 16,
  parameter int VF_PARENT_PF = 0,
  parameter int UPD_GAP      = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_wr,
  input  logic                      cfg_wr_vf_active,
  input  logic [1:0]                cfg_wr_pf_num,
  input  logic [10:0]               cfg_wr_vf_num,
  input  logic [CTL_SHDW_CFG_W-1:0] cfg_wr_data,
  output logic                      cfg_wr_err,
  input  logic                      ctl_shdw_req_all,
  output logic                      ctl_shdw_update,
  output logic [1:0]                ctl_shdw_pf_num,
  output logic [10:0]               ctl_shdw_vf_num,
  output logic                      ctl_shdw_vf_active,
  output logic [CTL_SHDW_CFG_W-1:0] ctl_shdw_cfg,
  output logic                      busy
`ifdef CTL_SHDW_STATS_EN
  ,
  output logic [31:0]               upd_cnt,
  output logic [15:0]               sweep_cnt
`endif
);

  localparam int N  = NUM_PF + NUM_VF;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int GW = (UPD_GAP > 1) ? $clog2(UPD_GAP + 1) : 1;

  logic [CTL_SHDW_CFG_W-1:0] tbl [N];
  logic [N-1:0]              dirty;
  logic                      sweep_pend;
  logic                      req_all_q;
  logic                      in_sweep;
  t_shdw_tx_state            state;
  logic [IW-1:0]             idx;
  logic [GW-1:0]             gap_cnt;
  t_ctl_shdw                 shdw_q;
  logic                      update_q;
  logic                      err_q;

  logic                      wr_ok;
  logic [IW-1:0]             wr_idx;
  logic                      wr_hit;
  logic                      wr_bad;
  logic                      req_edge;
  logic                      last_idx;
  logic                      pick_any;
  logic [IW-1:0]             pick_idx;
  t_ctl_shdw                 emit_val;

  pcie_ctl_shdw_pick #(.N(N), .IW(IW)) u_pick (
    .vec     (dirty),
    .any_set (pick_any),
    .low_idx (pick_idx)
  );

  // Decode the write address into a flat table index and range-check it.
  always_comb begin
    wr_ok  = 1'b0;
    wr_idx = '0;
    if (cfg_wr_vf_active) begin
      wr_ok  = int'(cfg_wr_vf_num) < NUM_VF;
      wr_idx = IW'(NUM_PF + int'(cfg_wr_vf_num));
    end else begin
      wr_ok  = int'(cfg_wr_pf_num) < NUM_PF;
      wr_idx = IW'(cfg_wr_pf_num);
    end
  end

  assign wr_hit   = cfg_wr & wr_ok;
  assign wr_bad   = cfg_wr & ~wr_ok;
  assign req_edge = ctl_shdw_req_all & ~req_all_q;
  assign last_idx = (int'(idx) == N - 1);

  // Build the outgoing record for the currently selected table index.
  always_comb begin
    emit_val     = '0;
    emit_val.cfg = tbl[idx];
    if (int'(idx) >= NUM_PF) begin
      emit_val.pf_num    = 2'(VF_PARENT_PF);
      emit_val.vf_num    = 11'(int'(idx) - NUM_PF);
      emit_val.vf_active = 1'b1;
    end else begin
      emit_val.pf_num = 2'(idx);
    end
  end

  // Shadow table storage; out-of-range writes never reach here.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) tbl[i] <= '0;
    end else if (wr_hit) begin
      tbl[wr_idx] <= cfg_wr_data;
    end
  end

  // Sequencer: sweep/emit selection, dirty tracking and registered outputs.
  // A write landing on the entry being emitted re-sets its dirty bit because
  // the write assignment comes last, so the new value is sent again later.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      gap_cnt    <= '0;
      dirty      <= '0;
      sweep_pend <= 1'b0;
      req_all_q  <= 1'b0;
      in_sweep   <= 1'b0;
      update_q   <= 1'b0;
      shdw_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      update_q  <= 1'b0;
      shdw_q    <= '0;
      err_q     <= wr_bad;
      req_all_q <= ctl_shdw_req_all;
      case (state)
        IDLE: begin
          if (sweep_pend) begin
            state      <= SWEEP;
            idx        <= '0;
            in_sweep   <= 1'b1;
            sweep_pend <= 1'b0;
          end else if (pick_any) begin
            state <= EMIT;
            idx   <= pick_idx;
          end
        end
        SWEEP: begin
          update_q   <= 1'b1;
          shdw_q     <= emit_val;
          dirty[idx] <= 1'b0;
          if (last_idx) in_sweep <= 1'b0;
          else          idx      <= idx + 1'b1;
          if (UPD_GAP > 0) begin
            state   <= GAP;
            gap_cnt <= GW'(UPD_GAP);
          end else if (last_idx) begin
            state <= IDLE;
          end
        end
        EMIT: begin
          update_q   <= 1'b1;
          shdw_q     <= emit_val;
          dirty[idx] <= 1'b0;
          if (UPD_GAP > 0) begin
            state   <= GAP;
            gap_cnt <= GW'(UPD_GAP);
          end else begin
            state <= IDLE;
          end
        end
        GAP: begin
          if (gap_cnt == GW'(1)) state <= in_sweep ? SWEEP : IDLE;
          else                   gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
      if (wr_hit)   dirty[wr_idx] <= 1'b1;
      if (req_edge) sweep_pend    <= 1'b1;
    end
  end

  assign cfg_wr_err         = err_q;
  assign ctl_shdw_update    = update_q;
  assign ctl_shdw_pf_num    = shdw_q.pf_num;
  assign ctl_shdw_vf_num    = shdw_q.vf_num;
  assign ctl_shdw_vf_active = shdw_q.vf_active;
  assign ctl_shdw_cfg       = shdw_q.cfg;
  assign busy               = sweep_pend | in_sweep | (|dirty);

`ifdef CTL_SHDW_STATS_EN
  // Saturating pulse and completed-sweep counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      upd_cnt   <= '0;
      sweep_cnt <= '0;
    end else begin
      if ((state == SWEEP || state == EMIT) && upd_cnt != '1)
        upd_cnt <= upd_cnt + 32'd1;
      if (state == SWEEP && last_idx && sweep_cnt != '1)
        sweep_cnt <= sweep_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pcie_ctl_shdw_tx.sv
// Self-checking bench for pcie_ctl_shdw_tx: directed scenarios plus a
// randomized write burst checked against a table model of the shadow.
module tb_pcie_ctl_shdw_tx;
  localparam int NUM_PF       = 4;
  localparam int NUM_VF       = 16;
  localparam int VF_PARENT_PF = 0;
  localparam int UPD_GAP      = 2;
  localparam int N            = NUM_PF + NUM_VF;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_wr;
  logic        cfg_wr_vf_active;
  logic [1:0]  cfg_wr_pf_num;
  logic [10:0] cfg_wr_vf_num;
  logic [6:0]  cfg_wr_data;
  logic        cfg_wr_err;
  logic        ctl_shdw_req_all;
  logic        ctl_shdw_update;
  logic [1:0]  ctl_shdw_pf_num;
  logic [10:0] ctl_shdw_vf_num;
  logic        ctl_shdw_vf_active;
  logic [6:0]  ctl_shdw_cfg;
  logic        busy;
`ifdef CTL_SHDW_STATS_EN
  logic [31:0] upd_cnt;
  logic [15:0] sweep_cnt;
`endif

  pcie_ctl_shdw_tx #(
    .NUM_PF(NUM_PF), .NUM_VF(NUM_VF), .VF_PARENT_PF(VF_PARENT_PF), .UPD_GAP(UPD_GAP)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .cfg_wr             (cfg_wr),
    .cfg_wr_vf_active   (cfg_wr_vf_active),
    .cfg_wr_pf_num      (cfg_wr_pf_num),
    .cfg_wr_vf_num      (cfg_wr_vf_num),
    .cfg_wr_data        (cfg_wr_data),
    .cfg_wr_err         (cfg_wr_err),
    .ctl_shdw_req_all   (ctl_shdw_req_all),
    .ctl_shdw_update    (ctl_shdw_update),
    .ctl_shdw_pf_num    (ctl_shdw_pf_num),
    .ctl_shdw_vf_num    (ctl_shdw_vf_num),
    .ctl_shdw_vf_active (ctl_shdw_vf_active),
    .ctl_shdw_cfg       (ctl_shdw_cfg),
    .busy               (busy)
`ifdef CTL_SHDW_STATS_EN
    ,
    .upd_cnt            (upd_cnt),
    .sweep_cnt          (sweep_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          idx;
    logic [6:0]  cfg;
    int          cyc;
    logic [1:0]  pf;
    logic [10:0] vf;
    logic        vfa;
  } rec_t;

  rec_t pq[$];
  int   err_cnt  = 0;
  int   hold_bad = 0;
  int   checks   = 0;
  int   errors   = 0;

  logic [6:0] mtbl [N];
  bit         written [N];

  // Pulse monitor: records every update and watches idle fields stay zero.
  always @(negedge clk) begin
    rec_t r;
    if (ctl_shdw_update === 1'b1) begin
      r.idx = ctl_shdw_vf_active ? NUM_PF + int'(ctl_shdw_vf_num) : int'(ctl_shdw_pf_num);
      r.cfg = ctl_shdw_cfg;
      r.cyc = cyc;
      r.pf  = ctl_shdw_pf_num;
      r.vf  = ctl_shdw_vf_num;
      r.vfa = ctl_shdw_vf_active;
      pq.push_back(r);
    end else if ({ctl_shdw_pf_num, ctl_shdw_vf_num, ctl_shdw_vf_active, ctl_shdw_cfg} !== 21'd0) begin
      hold_bad++;
    end
    if (cfg_wr_err === 1'b1) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic vfa, input logic [1:0] pf, input logic [10:0] vf, input logic [6:0] d);
    cfg_wr           = 1'b1;
    cfg_wr_vf_active = vfa;
    cfg_wr_pf_num    = pf;
    cfg_wr_vf_num    = vf;
    cfg_wr_data      = d;
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) chk("idle_timeout", busy, 0);
    repeat (UPD_GAP + 3) step();
  endtask

  task automatic consist();
    foreach (pq[k]) begin
      if (pq[k].vfa) chk("vf_parent_pf", 32'(pq[k].pf), VF_PARENT_PF);
      else           chk("pf_vf_num_zero", 32'(pq[k].vf), 0);
    end
  endtask

  // Expect exactly one full sweep in the queue matching the model table.
  task automatic sweep_check(input string tag);
    chk({tag, "_count"}, pq.size(), N);
    if (pq.size() == N) begin
      for (int i = 0; i < N; i++) begin
        chk({tag, "_idx"}, pq[i].idx, i);
        chk({tag, "_cfg"}, 32'(pq[i].cfg), 32'(mtbl[i]));
        if (i > 0) chk({tag, "_spacing"}, pq[i].cyc - pq[i-1].cyc, 1 + UPD_GAP);
      end
    end
  endtask

  task automatic wait_pulse_vf(input int vf, output bit found);
    int n = 0;
    found = 0;
    while (!found && n < 400) begin
      step();
      n++;
      if (ctl_shdw_update === 1'b1 && ctl_shdw_vf_active === 1'b1 && int'(ctl_shdw_vf_num) == vf)
        found = 1;
    end
  endtask

  initial begin
    bit         found;
    int         cnt;
    int         exp_err;
    logic [6:0] old;
    logic [6:0] lastv;

    reset = 1'b1;
    cfg_wr = 1'b0; cfg_wr_vf_active = 1'b0; cfg_wr_pf_num = '0;
    cfg_wr_vf_num = '0; cfg_wr_data = '0; ctl_shdw_req_all = 1'b0;
    for (int i = 0; i < N; i++) begin mtbl[i] = '0; written[i] = 0; end
    repeat (3) step();

    // Reset state
    chk("rst_update", ctl_shdw_update, 0);
    chk("rst_err", cfg_wr_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fields", {ctl_shdw_pf_num, ctl_shdw_vf_num, ctl_shdw_vf_active, ctl_shdw_cfg}, 0);
`ifdef CTL_SHDW_STATS_EN
    chk("rst_upd_cnt", upd_cnt, 0);
    chk("rst_sweep_cnt", sweep_cnt, 0);
`endif
    reset = 1'b0;
    step();

    // 1: single VF0 write
    pq.delete();
    wr(1'b1, 2'd0, 11'd0, 7'h06); mtbl[NUM_PF] = 7'h06;
    wait_idle(200);
    chk("t1_count", pq.size(), 1);
    if (pq.size() >= 1) begin
      chk("t1_vfa", pq[0].vfa, 1);
      chk("t1_vf", 32'(pq[0].vf), 0);
      chk("t1_pf", 32'(pq[0].pf), 0);
      chk("t1_cfg", 32'(pq[0].cfg), 32'h06);
    end
    chk("t1_busy", busy, 0);

    // 2: PF2 then VF5 back to back
    pq.delete();
    wr(1'b0, 2'd2, 11'd0, 7'h01); mtbl[2] = 7'h01;
    wr(1'b1, 2'd0, 11'd5, 7'h04); mtbl[NUM_PF+5] = 7'h04;
    wait_idle(200);
    chk("t2_count", pq.size(), 2);
    if (pq.size() == 2) begin
      chk("t2_first_idx", pq[0].idx, 2);
      chk("t2_first_cfg", 32'(pq[0].cfg), 32'h01);
      chk("t2_second_idx", pq[1].idx, NUM_PF + 5);
      chk("t2_second_cfg", 32'(pq[1].cfg), 32'h04);
      chk("t2_gap_ok", (pq[1].cyc - pq[0].cyc) >= 1 + UPD_GAP, 1);
    end
    consist();

    // 3: full sweep on rising edge, level held
    pq.delete();
    ctl_shdw_req_all = 1'b1;
    step();
    wait_idle(400);
    repeat (60) step();
    sweep_check("t3");
    consist();
    ctl_shdw_req_all = 1'b0;
    repeat (3) step();

    // 4: write VF3 in the cycle it is selected in a sweep
    pq.delete();
    ctl_shdw_req_all = 1'b1;
    step();
    wait_pulse_vf(2, found);
    chk("t4_find_vf2", found, 1);
    repeat (UPD_GAP) step();
    old = mtbl[NUM_PF+3];
    wr(1'b1, 2'd0, 11'd3, 7'h02);
    wait_idle(400);
    chk("t4_count", pq.size(), N + 1);
    if (pq.size() == N + 1) begin
      for (int i = 0; i < N; i++) begin
        chk("t4_sweep_idx", pq[i].idx, i);
        chk("t4_sweep_cfg", 32'(pq[i].cfg), (i == NUM_PF + 3) ? 32'(old) : 32'(mtbl[i]));
      end
      chk("t4_extra_idx", pq[N].idx, NUM_PF + 3);
      chk("t4_extra_cfg", 32'(pq[N].cfg), 32'h02);
    end
    mtbl[NUM_PF+3] = 7'h02;
    ctl_shdw_req_all = 1'b0;
    repeat (3) step();

    // 5: out-of-range VF write
    pq.delete();
    err_cnt = 0;
    wr(1'b1, 2'd0, 11'd16, 7'h7f);
    chk("t5_err_pulse", cfg_wr_err, 1);
    step();
    chk("t5_err_single", cfg_wr_err, 0);
    repeat (10) step();
    chk("t5_no_update", pq.size(), 0);
    chk("t5_busy", busy, 0);
    chk("t5_err_cnt", err_cnt, 1);

    // Randomized write burst against the table model
    pq.delete();
    err_cnt = 0;
    exp_err = 0;
    for (int i = 0; i < N; i++) written[i] = 0;
    for (int k = 0; k < 40; k++) begin
      logic       vfa;
      logic [1:0] pf;
      int         vf;
      logic [6:0] d;
      int         ix;
      vfa = 1'($urandom_range(0, 1));
      pf  = 2'($urandom_range(0, 3));
      vf  = $urandom_range(0, NUM_VF + 3);
      d   = 7'($urandom);
      if (vfa && vf >= NUM_VF) begin
        exp_err++;
      end else begin
        ix = vfa ? NUM_PF + vf : int'(pf);
        mtbl[ix] = d;
        written[ix] = 1;
      end
      wr(vfa, pf, 11'(vf), d);
      repeat ($urandom_range(0, 3)) step();
    end
    wait_idle(2000);
    chk("rnd_err_cnt", err_cnt, exp_err);
    for (int i = 0; i < N; i++) begin
      cnt = 0;
      lastv = '0;
      foreach (pq[k]) if (pq[k].idx == i) begin cnt++; lastv = pq[k].cfg; end
      if (written[i]) begin
        chk("rnd_seen", cnt > 0, 1);
        chk("rnd_last_cfg", 32'(lastv), 32'(mtbl[i]));
      end else begin
        chk("rnd_unwritten_quiet", cnt, 0);
      end
    end
    consist();
    pq.delete();
    ctl_shdw_req_all = 1'b1;
    step();
    wait_idle(400);
    sweep_check("rnd_sweep");
    ctl_shdw_req_all = 1'b0;
    repeat (3) step();

    // 6: reset in the middle of a sweep
    pq.delete();
    ctl_shdw_req_all = 1'b1;
    step();
    wait_pulse_vf(3, found);
    chk("t6_find_vf3", found, 1);
    reset = 1'b1;
    ctl_shdw_req_all = 1'b0;
    step();
    pq.delete();
    reset = 1'b0;
    for (int i = 0; i < N; i++) mtbl[i] = '0;
    repeat (40) step();
    chk("t6_no_pulses", pq.size(), 0);
    chk("t6_busy", busy, 0);
    ctl_shdw_req_all = 1'b1;
    step();
    wait_idle(400);
    sweep_check("t6_sweep");
`ifdef CTL_SHDW_STATS_EN
    chk("t6_upd_cnt", upd_cnt, 20);
    chk("t6_sweep_cnt", sweep_cnt, 1);
`endif
    ctl_shdw_req_all = 1'b0;
    step();

    chk("idle_fields_zero", hold_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
